mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 43 ++++
 rtl/mem_arbiter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: IF fetch channel, MEM load/store channel and the byte-wide RAM port.
// master = requesters plus RAM model side, slave = the arbiter itself.
interface mem_arbiter_if #(
  parameter int ADDR_W = 18
);
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_flush_i;
  logic [31:0]       if_data_o;
  logic              if_done_o;

  logic              mem_req_i;
  logic              mem_we_i;
  logic [ADDR_W-1:0] mem_addr_i;
  logic [1:0]        mem_len_i;
  logic [31:0]       mem_wdata_i;
  logic [31:0]       mem_rdata_o;
  logic              mem_done_o;
  logic              busy_o;

  logic [ADDR_W-1:0] ram_addr_o;
  logic              ram_wr_o;
  logic [7:0]        ram_dout_o;
  logic [7:0]        ram_din_i;

  modport master (
    output if_req_i, if_addr_i, if_flush_i,
    input  if_data_o, if_done_o,
    output mem_req_i, mem_we_i, mem_addr_i, mem_len_i, mem_wdata_i,
    input  mem_rdata_o, mem_done_o, busy_o,
    input  ram_addr_o, ram_wr_o, ram_dout_o,
    output ram_din_i
  );

  modport slave (
    input  if_req_i, if_addr_i, if_flush_i,
    output if_data_o, if_done_o,
    input  mem_req_i, mem_we_i, mem_addr_i, mem_len_i, mem_wdata_i,
    output mem_rdata_o, mem_done_o, busy_o,
    output ram_addr_o, ram_wr_o, ram_dout_o,
    input  ram_din_i
  );
endinterface

// File: rtl/mem_arbiter.sv
// Byte-serial arbiter sharing one 8-bit RAM port between instruction fetch and load/store.
// Define MEM_ARB_FAIR_EN to alternate grants on contention; default is fixed MEM priority.
module mem_arbiter #(
  parameter int ADDR_W = 18
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, IF_RD, MEM_RD, MEM_WR} state_t;

  state_t            state_reg;
  logic [2:0]        cnt_reg;
  logic [2:0]        last_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdata_reg;
  logic [31:0]       buf_reg;
  logic [31:0]       if_data_reg;
  logic [31:0]       mem_rdata_reg;
  logic              if_done_reg;
  logic              mem_done_reg;
  logic              busy_reg;
  logic [ADDR_W-1:0] ram_addr_reg;
  logic              ram_wr_reg;
  logic [7:0]        ram_dout_reg;
`ifdef MEM_ARB_FAIR_EN
  logic              last_mem_reg;
`endif

  logic [2:0]        cnt_next;
  logic [2:0]        len_last;
  logic [31:0]       word_next;
  logic [7:0]        wr_lane [4];
  logic [7:0]        wr_byte_next;
  logic              idle_ok;
  logic              if_ok;
  logic              grant_mem;
  logic              grant_if;

  assign cnt_next     = cnt_reg + 3'd1;
  assign len_last     = bus.mem_len_i[1] ? 3'd3 : (bus.mem_len_i[0] ? 3'd1 : 3'd0);
  assign wr_byte_next = wr_lane[cnt_next[1:0]];

  // Lane cnt_reg takes the byte returned for the address presented last cycle.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign word_next[8*gi +: 8] = (cnt_reg[1:0] == 2'(gi)) ? bus.ram_din_i : buf_reg[8*gi +: 8];
      assign wr_lane[gi]          = wdata_reg[8*gi +: 8];
    end
  endgenerate

  // A done pulse still high blocks the grant, giving one idle edge between transactions.
  assign idle_ok = (state_reg == IDLE) && !if_done_reg && !mem_done_reg;
  assign if_ok   = bus.if_req_i && !bus.if_flush_i;
`ifdef MEM_ARB_FAIR_EN
  assign grant_mem = idle_ok && bus.mem_req_i && !(if_ok && last_mem_reg);
`else
  assign grant_mem = idle_ok && bus.mem_req_i;
`endif
  assign grant_if = idle_ok && if_ok && !grant_mem;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= 3'd0;
      last_reg      <= 3'd0;
      addr_reg      <= '0;
      wdata_reg     <= 32'd0;
      buf_reg       <= 32'd0;
      if_data_reg   <= 32'd0;
      mem_rdata_reg <= 32'd0;
      if_done_reg   <= 1'b0;
      mem_done_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      ram_addr_reg  <= '0;
      ram_wr_reg    <= 1'b0;
      ram_dout_reg  <= 8'd0;
`ifdef MEM_ARB_FAIR_EN
      last_mem_reg  <= 1'b0;
`endif
    end else begin
      if_done_reg  <= 1'b0;
      mem_done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          cnt_reg <= 3'd0;
          buf_reg <= 32'd0;
          if (grant_mem) begin
            state_reg    <= bus.mem_we_i ? MEM_WR : MEM_RD;
            addr_reg     <= bus.mem_addr_i;
            last_reg     <= len_last;
            wdata_reg    <= bus.mem_wdata_i;
            ram_addr_reg <= bus.mem_addr_i;
            ram_wr_reg   <= bus.mem_we_i;
            ram_dout_reg <= bus.mem_wdata_i[7:0];
            busy_reg     <= 1'b1;
`ifdef MEM_ARB_FAIR_EN
            last_mem_reg <= 1'b1;
`endif
          end else if (grant_if) begin
            state_reg    <= IF_RD;
            addr_reg     <= bus.if_addr_i;
            last_reg     <= 3'd3;
            ram_addr_reg <= bus.if_addr_i;
            busy_reg     <= 1'b1;
`ifdef MEM_ARB_FAIR_EN
            last_mem_reg <= 1'b0;
`endif
          end
        end
        IF_RD: begin
          if (bus.if_flush_i) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else if (cnt_reg == last_reg) begin
            if_data_reg <= word_next;
            if_done_reg <= 1'b1;
            state_reg   <= IDLE;
            busy_reg    <= 1'b0;
          end else begin
            buf_reg      <= word_next;
            cnt_reg      <= cnt_next;
            ram_addr_reg <= addr_reg + ADDR_W'(cnt_next);
          end
        end
        MEM_RD: begin
          if (cnt_reg == last_reg) begin
            mem_rdata_reg <= word_next;
            mem_done_reg  <= 1'b1;
            state_reg     <= IDLE;
            busy_reg      <= 1'b0;
          end else begin
            buf_reg      <= word_next;
            cnt_reg      <= cnt_next;
            ram_addr_reg <= addr_reg + ADDR_W'(cnt_next);
          end
        end
        MEM_WR: begin
          if (cnt_reg == last_reg) begin
            ram_wr_reg   <= 1'b0;
            mem_done_reg <= 1'b1;
            state_reg    <= IDLE;
            busy_reg     <= 1'b0;
          end else begin
            cnt_reg      <= cnt_next;
            ram_addr_reg <= addr_reg + ADDR_W'(cnt_next);
            ram_dout_reg <= wr_byte_next;
          end
        end
      endcase
    end
  end

  assign bus.if_data_o   = if_data_reg;
  assign bus.if_done_o   = if_done_reg;
  assign bus.mem_rdata_o = mem_rdata_reg;
  assign bus.mem_done_o  = mem_done_reg;
  assign bus.busy_o      = busy_reg;
  assign bus.ram_addr_o  = ram_addr_reg;
  assign bus.ram_wr_o    = ram_wr_reg;
  assign bus.ram_dout_o  = ram_dout_reg;

endmodule
